serial_rx_frame: RTL and testbench
==================================

// Module: serial_rx_frame
//
// PURPOSE
// UART-style 8N1 frame receiver fed by the 1-bit synchronizer output.
// The rx line has already been synchronized; this block only does framing.
// It finds the start bit and samples each bit at its midpoint.
// Each received byte goes into a one-entry holding register with a valid/dequeue handshake.
// It sits between the rx-pin synchronizer and the memory-mapped serial peripheral.
//
// PARAMETERS
// CLOCKS_PER_BIT  16  clk cycles per serial bit; even, >= 4. Counter width = $clog2(CLOCKS_PER_BIT).
//
// PORTS
// clk           in   1  system clock; all logic on posedge
// reset_n       in   1  asynchronous, active-low reset
// rx_sync       in   1  synchronized serial line; idle = 1
// rx_dequeue    in   1  consumer takes rx_data this cycle; ignored when rx_valid = 0
// rx_data       out  8  last received byte, held stable while rx_valid = 1
// rx_valid      out  1  holding register full (level)
// frame_error   out  1  one-cycle pulse: stop bit sampled as 0
// overrun       out  1  one-cycle pulse: a new byte overwrote an unconsumed byte
//
// BEHAVIOUR
// Reset (reset_n = 0, any cycle, including mid-frame):
// - State goes to IDLE; counter, bit index and shift register clear to 0.
// - rx_data = 8'h00, rx_valid = 0, frame_error = 0, overrun = 0.
// - Takes effect immediately, without waiting for a clock edge.
// HALF = CLOCKS_PER_BIT/2. The counter decrements every cycle outside IDLE and WAIT_HIGH.
// "Tick" = a cycle in which counter == 0.
// State machine:
// - IDLE: on rx_sync == 0, set counter = HALF-1 and go to START.
// - START, on tick:
//   - rx_sync == 0: set counter = CLOCKS_PER_BIT-1, bit index = 0, go to DATA.
//   - rx_sync == 1: treat as a glitch; go to IDLE with no outputs.
// - DATA, on tick:
//   - Shift in LSB first: shift <= {rx_sync, shift[7:1]}.
//   - Set counter = CLOCKS_PER_BIT-1.
//   - After bit index 7, go to STOP; otherwise increment bit index.
// - STOP, on tick:
//   - rx_sync == 1: load the byte into the holding register and go to IDLE.
//   - rx_sync == 0: pulse frame_error, discard the byte, go to WAIT_HIGH.
// - WAIT_HIGH: stay until rx_sync == 1, then go to IDLE.
//   This stops a break condition from retriggering frames.
// Holding register, all updates registered:
// - Load with rx_valid = 0: rx_data = byte, rx_valid = 1.
// - Load with rx_valid = 1 and rx_dequeue = 1 in the same cycle:
//   rx_data = new byte, rx_valid stays 1, no overrun.
// - Load with rx_valid = 1 and rx_dequeue = 0:
//   rx_data = new byte, rx_valid stays 1, overrun pulses for 1 cycle.
// - Dequeue with no load: rx_valid = 0 next cycle; rx_data keeps its value.
// Latency: let E be the edge at which IDLE first sees rx_sync == 0.
// - STOP is sampled HALF + 9*CLOCKS_PER_BIT cycles after E.
// - rx_valid or frame_error is visible right after that edge.
// - With CLOCKS_PER_BIT = 16 this is 152 cycles.
// A new start bit is accepted in the cycle after leaving STOP, so back-to-back frames work.
// rx_sync is treated as fully synchronous; no extra filtering is applied.
//
// TESTING
// (All scenarios use CLOCKS_PER_BIT = 16, 16-cycle bits.)
// 1. Single frame: send 0xA5 -> rx_valid rises 152 cycles after start is seen, rx_data = 0xA5;
//    dequeue -> rx_valid = 0.
// 2. Glitch: pulse rx_sync low for 3 cycles -> no rx_valid and no frame_error; FSM back in IDLE;
//    a following 0x3C frame is received correctly.
// 3. Break: hold rx_sync = 0 for 40 bit times -> exactly one frame_error pulse and no rx_valid;
//    after the line returns high, 0x81 is received.
// 4. Overrun: send 0x00 then 0xFF back-to-back with no dequeue -> one overrun pulse, rx_data = 0xFF,
//    rx_valid = 1.
// 5. Same-cycle dequeue: assert rx_dequeue in the cycle 0xFF loads over 0x00 -> no overrun,
//    rx_valid = 1, rx_data = 0xFF.
// 6. Reset mid-frame: drop reset_n during bit 4 of 0x55 -> all outputs 0 at once; after release,
//    a 0xC3 frame is received correctly.

Source files
------------

// File: rtl/serial_rx_frame.sv
// 8N1 serial frame receiver: finds the start bit, samples each bit at its
// midpoint and hands bytes over through a one-entry holding register.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   rx_sync      synchronized serial line, idle high
//   rx_dequeue   consumer takes rx_data this cycle
//   rx_data      last received byte, stable while rx_valid is high
//   rx_valid     holding register full
//   frame_error  one-cycle pulse when the stop bit is sampled low
//   overrun      one-cycle pulse when a new byte replaces an unread one
module serial_rx_frame #(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_sync,
    input  logic       rx_dequeue,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    overrun
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] count;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;
    logic          load;
    logic          stop_bad;

    always_comb begin
        tick     = (count == '0);
        load     = (state == STOP) && tick && rx_sync;
        stop_bad = (state == STOP) && tick && !rx_sync;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        count <= HALF_M1;
                        state <= START;
                    end
                end
                START: begin
                    if (!tick) begin
                        count <= count - 1'b1;
                    end else if (!rx_sync) begin
                        count   <= FULL_M1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        // Start bit gone at its midpoint: a glitch.
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        count <= count - 1'b1;
                    end else begin
                        shift <= {rx_sync, shift[7:1]};
                        count <= FULL_M1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (!tick) begin
                        count <= count - 1'b1;
                    end else if (rx_sync) begin
                        state <= IDLE;
                    end else begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not start new frames.
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            overrun     <= load && rx_valid && !rx_dequeue;
            if (load) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_dequeue) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_frame.sv
// Bench for serial_rx_frame: table of frames plus hand-written sequences,
// with a cycle-stamped scoreboard checking every byte load.
module tb_serial_rx_frame;

    logic       clk;
    logic       reset_n;
    logic       rx_sync;
    logic       rx_dequeue;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;

    serial_rx_frame #(.CLOCKS_PER_BIT(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_sync     (rx_sync),
        .rx_dequeue  (rx_dequeue),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       deq_before;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    logic prev_valid = 1'b0;
    logic model_valid = 1'b0;
    logic [7:0] model_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each expected byte carries the cycle it must appear in.
    always @(negedge clk) begin
        logic popped;
        exp_t e;
        popped = 1'b0;
        if (reset_n) begin
            if (frame_error) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                popped = 1'b1;
                check("load_cycle", cyc, e.due);
                check("load_valid", rx_valid, 1'b1);
                check("load_data", rx_data, e.data);
                check("load_overrun", overrun, e.ovr);
            end
            if (rx_valid && !prev_valid && !popped)
                check("unexpected_valid", 1'b1, 1'b0);
            prev_valid = rx_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic idle(int n);
        rx_sync = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(logic v, int n);
        rx_sync = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Entered and left at posedge+1. deq raises rx_dequeue in the load cycle.
    task automatic send_frame(logic [7:0] b, logic stop, logic deq);
        exp_t e;
        int   start;
        start = cyc;
        if (stop) begin
            e.data = b;
            e.due  = start + 153;
            e.ovr  = model_valid && !deq;
            sb.push_back(e);
            model_valid = 1'b1;
            model_data  = b;
        end
        drive_bit(1'b0, 16);
        for (int k = 0; k < 8; k++) drive_bit(b[k], 16);
        for (int i = 0; i < 16; i++) begin
            rx_sync    = stop;
            rx_dequeue = deq && (i == 8);
            @(posedge clk);
            #1;
        end
        rx_dequeue = 1'b0;
        rx_sync    = 1'b1;
    endtask

    task automatic dequeue();
        rx_dequeue = 1'b1;
        @(posedge clk);
        #1;
        rx_dequeue = 1'b0;
        model_valid = 1'b0;
        check("deq_valid", rx_valid, 1'b0);
        check("deq_data_kept", rx_data, model_data);
    endtask

    vec_t vecs[4];

    initial begin
        int f0;
        int o0;
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'hA5, 1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 0};
        vecs[3] = '{8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 0};

        reset_n    = 1'b0;
        rx_sync    = 1'b1;
        rx_dequeue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        reset_n = 1'b1;
        idle(4);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].deq_before) dequeue();
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            idle(4);
            check("vec_valid", rx_valid, vecs[i].exp_valid);
            check("vec_data", rx_data, vecs[i].exp_data);
            check("vec_ferr", ferr_cnt - f0, vecs[i].exp_ferr);
        end

        // Glitch: 3 low cycles, then a real frame.
        dequeue();
        f0 = ferr_cnt;
        drive_bit(1'b0, 3);
        idle(30);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);

        // Break: 40 bit times low.
        dequeue();
        f0 = ferr_cnt;
        drive_bit(1'b0, 640);
        idle(32);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_valid", rx_valid, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);

        // Overrun: back-to-back without dequeue.
        dequeue();
        o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(4);
        check("ovr_count", ovr_cnt - o0, 1);
        check("ovr_data", rx_data, 8'hFF);
        check("ovr_valid", rx_valid, 1'b1);

        // Dequeue in the very cycle of the load.
        dequeue();
        o0 = ovr_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(4);
        check("samecyc_ovr", ovr_cnt - o0, 0);
        check("samecyc_valid", rx_valid, 1'b1);
        check("samecyc_data", rx_data, 8'hFF);

        // Reset in the middle of bit 4 of 0x55, asserted between edges.
        drive_bit(1'b0, 16);
        for (int k = 0; k < 4; k++) drive_bit(k[0] ? 1'b0 : 1'b1, 16);
        drive_bit(1'b1, 8);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_ferr", frame_error, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        sb.delete();
        model_valid = 1'b0;
        model_data  = 8'h00;
        rx_sync     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(4);
        check("post_rst_data", rx_data, 8'hC3);
        check("post_rst_valid", rx_valid, 1'b1);

        idle(8);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
